// File: rtl/gate2_truth_table_checker_if.sv
// Bundle of every signal between the truth-table checker and its neighbours:
// the run-control/result side (start, busy, done, pass, err_count, fail_vec,
// captured), the gate-under-test side (a, b, y) and the FSM state for probing.
//
// Handshake: start is a level request sampled on rising edges and honoured
// only while the checker is idle; busy is high from the accepting edge until
// the done cycle ends; done is a single-cycle pulse marking the results as
// final. Results hold until the next accepted start. Nothing is queued.
`timescale 1ns/1ps
interface gate2_truth_table_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    logic [3:0] captured;
    logic [1:0] state;

    // Environment side: issues start, plays the gate, reads the results.
    modport master (
        output start,
        output y,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec,
        input  captured,
        input  state
    );

    // Checker side.
    modport slave (
        input  start,
        input  y,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec,
        output captured,
        output state
    );
endinterface

// File: rtl/gate2_truth_table_checker.sv
// Exhaustive checker for a 2-input gate: walks {a,b} through 00..11, lets
// each combination settle for SETTLE_CYCLES cycles, samples y once, and
// compares it against the EXPECT truth table.
`timescale 1ns/1ps
module gate2_truth_table_checker #(
    parameter int         SETTLE_CYCLES = 2,      // 0..15
    parameter logic [3:0] EXPECT        = 4'b1110 // bit i: expected y for {a,b}=i
) (
    input  logic                          clk,
    input  logic                          rst,
    gate2_truth_table_checker_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state_q, state_n;
    logic [1:0] idx_q, idx_n;
    logic [3:0] cnt_q, cnt_n;
    logic       a_q, a_n;
    logic       b_q, b_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;
    logic       pass_q, pass_n;
    logic [2:0] err_q, err_n;
    logic [3:0] fail_q, fail_n;
    logic [3:0] cap_q, cap_n;
    logic       mism;

    // State and result registers; reset wins over everything, aborting a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'b0000;
            cap_q   <= 4'b0000;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            a_q     <= a_n;
            b_q     <= b_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
            err_q   <= err_n;
            fail_q  <= fail_n;
            cap_q   <= cap_n;
        end
    end

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        a_n     = a_q;
        b_n     = b_q;
        busy_n  = busy_q;
        done_n  = done_q;
        pass_n  = pass_q;
        err_n   = err_q;
        fail_n  = fail_q;
        cap_n   = cap_q;
        mism    = bus.y ^ EXPECT[idx_q];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = SETTLE;
                    idx_n   = 2'd0;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    cnt_n   = SETTLE_LOAD;
                    busy_n  = 1'b1;
                    pass_n  = 1'b0;
                    err_n   = 3'd0;
                    fail_n  = 4'b0000;
                    cap_n   = 4'b0000;
                end
            end

            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_n = cnt_q - 4'd1;
                end else begin
                    // Sample edge: y has had SETTLE_CYCLES+1 cycles to settle.
                    cap_n[idx_q]  = bus.y;
                    fail_n[idx_q] = mism;
                    err_n         = err_q + {2'b00, mism};
                    if (idx_q != 2'd3) begin
                        idx_n      = idx_q + 2'd1;
                        {a_n, b_n} = idx_q + 2'd1;
                        cnt_n      = SETTLE_LOAD;
                    end else begin
                        // Last sample: park the gate inputs and publish the verdict,
                        // which must include the sample just taken.
                        state_n = DONE;
                        a_n     = 1'b0;
                        b_n     = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == 3'd0);
                    end
                end
            end

            DONE: begin
                done_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
    assign bus.captured  = cap_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_gate2_truth_table_checker.sv
// Directed bench for gate2_truth_table_checker: one instance with the default
// settle time in front of a switchable gate model, one with zero settle time
// in front of a plain OR gate.
`timescale 1ns/1ps
module tb_gate2_truth_table_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Gate model selector for dut_s2: 0 OR, 1 AND, 2 tied 0, 3 tied 1.
    logic [1:0] mode;

    gate2_truth_table_checker_if bus1 ();
    gate2_truth_table_checker_if bus2 ();

    function automatic logic gate_y(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign bus1.y = gate_y(mode, bus1.a, bus1.b);
    assign bus2.y = bus2.a | bus2.b;

    gate2_truth_table_checker #(.SETTLE_CYCLES(2), .EXPECT(4'b1110)) dut_s2 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    gate2_truth_table_checker #(.SETTLE_CYCLES(0), .EXPECT(4'b1110)) dut_s0 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // ---------------- scoreboard ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done1();
        int cyc = 0;
        while (bus1.done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("done_within_budget", 32'(bus1.done), 32'd1);
    endtask

    // One full run on dut_s2 with the hand-derived expected results.
    task automatic run1(input logic [3:0] cap, input logic [3:0] fail,
                        input logic [2:0] err, input logic pass);
        exp_q.push_back(cap);
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("busy_on_accept", 32'(bus1.busy), 32'd1);
        wait_done1();
        check("captured", 32'(bus1.captured), 32'(exp_q.pop_front()));
        check("fail_vec", 32'(bus1.fail_vec), 32'(fail));
        check("err_count", 32'(bus1.err_count), 32'(err));
        check("pass", 32'(bus1.pass), 32'(pass));
        tick();
        check("busy_after_done", 32'(bus1.busy), 32'd0);
        check("done_one_cycle", 32'(bus1.done), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         busy_cnt;
        int         done_cnt;
        logic [1:0] exp_ab;

        rst        = 1'b1;
        mode       = 2'd0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_state", 32'(bus1.state), 32'd0);
        check("rst_ab", 32'({bus1.a, bus1.b}), 32'd0);
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_done", 32'(bus1.done), 32'd0);
        check("rst_pass", 32'(bus1.pass), 32'd0);
        check("rst_err", 32'(bus1.err_count), 32'd0);
        check("rst_fail", 32'(bus1.fail_vec), 32'd0);
        check("rst_cap", 32'(bus1.captured), 32'd0);

        // 1: OR gate, input sequence, done timing and busy length
        mode = 2'd0;
        exp_q.push_back(4'b1110);
        busy_cnt   = 0;
        bus1.start = 1'b1;
        tick();                       // accept edge T
        bus1.start = 1'b0;
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) tick();
            busy_cnt += int'(bus1.busy);
            exp_ab = (j < 12) ? 2'(j / 3) : 2'd0;
            check("ab_seq", 32'({bus1.a, bus1.b}), 32'(exp_ab));
            check("done_timing", 32'(bus1.done), (j == 12) ? 32'd1 : 32'd0);
        end
        check("or_captured", 32'(bus1.captured), 32'(exp_q.pop_front()));
        check("or_fail", 32'(bus1.fail_vec), 32'd0);
        check("or_err", 32'(bus1.err_count), 32'd0);
        check("or_pass", 32'(bus1.pass), 32'd1);
        tick();
        check("or_busy_end", 32'(bus1.busy), 32'd0);
        check("or_busy_len", 32'(busy_cnt), 32'd13);
        check("or_hold_idle", 32'(bus1.captured), 32'b1110);

        // 2: AND gate in place of OR
        mode = 2'd1;
        run1(4'b1000, 4'b0110, 3'd2, 1'b0);

        // 3: y tied low, then tied high
        mode = 2'd2;
        run1(4'b0000, 4'b1110, 3'd3, 1'b0);
        mode = 2'd3;
        run1(4'b1111, 4'b0001, 3'd1, 1'b0);

        // 4: start held high -> back-to-back runs, results cleared at accept
        mode       = 2'd1;
        done_cnt   = 0;
        bus1.start = 1'b1;
        tick();                       // accept edge T
        for (int i = 1; i <= 28; i++) begin
            tick();
            done_cnt += int'(bus1.done);
            if (i == 12) check("b2b_cap_first", 32'(bus1.captured), 32'b1000);
            if (i == 13) check("b2b_idle_gap", 32'(bus1.busy), 32'd0);
            if (i == 14) begin
                check("b2b_reaccept", 32'(bus1.busy), 32'd1);
                check("b2b_cap_clear", 32'(bus1.captured), 32'd0);
                check("b2b_err_clear", 32'(bus1.err_count), 32'd0);
            end
        end
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        bus1.start = 1'b0;
        wait_done1();
        tick();

        // 5: reset at T+5 aborts the run
        mode       = 2'd3;
        bus1.start = 1'b1;
        tick();                       // T
        bus1.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // T+4
        check("pre_rst_cap", 32'(bus1.captured), 32'b0001);
        rst = 1'b1;
        tick();                       // T+5
        rst = 1'b0;
        check("abort_ab", 32'({bus1.a, bus1.b}), 32'd0);
        check("abort_busy", 32'(bus1.busy), 32'd0);
        check("abort_pass", 32'(bus1.pass), 32'd0);
        check("abort_err", 32'(bus1.err_count), 32'd0);
        check("abort_fail", 32'(bus1.fail_vec), 32'd0);
        check("abort_cap", 32'(bus1.captured), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            done_cnt += int'(bus1.done);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        mode = 2'd0;
        run1(4'b1110, 4'b0000, 3'd0, 1'b1);

        // 6: zero settle time on dut_s0
        bus2.start = 1'b1;
        tick();                       // T
        bus2.start = 1'b0;
        check("s0_ab0", 32'({bus2.a, bus2.b}), 32'd0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check("s0_ab", 32'({bus2.a, bus2.b}), (j < 4) ? 32'(j) : 32'd0);
            check("s0_done", 32'(bus2.done), (j == 4) ? 32'd1 : 32'd0);
        end
        check("s0_captured", 32'(bus2.captured), 32'b1110);
        check("s0_pass", 32'(bus2.pass), 32'd1);
        tick();
        check("s0_busy_end", 32'(bus2.busy), 32'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
